// File: rtl/diferencial_emisor_carriles.sv
// ---------------------------------------------------------------------------
// diferencial_emisor_carriles
//
// Multi-lane differential transmitter with sequenced electrical-idle handling.
// Each lane drives a true/complement pair from its serial data bit. A
// four-state machine enforces a minimum idle dwell, plays an alternating
// exit preamble before going active, and plays a fixed closing pattern
// before re-entering idle.
//
// Optional feature macro: POLARIDAD_INVERTIBLE_EN
//   When defined, the polaridad port exists and any lane with polaridad[i]=1
//   has its P/N legs swapped outside IDLE.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset (priority over enb)
//   enb        in   enable; low holds state, counter and outputs
//   TxElecIdle in   electrical-idle request
//   entrada    in   [CARRILES] serial data bit per lane
//   polaridad  in   [CARRILES] per-lane leg swap (macro only)
//   salidaP    out  [CARRILES] true leg per lane (registered)
//   salidaN    out  [CARRILES] complement leg per lane (registered)
//   enIdle     out  high while the state is IDLE (registered)
//   listo      out  high while the state is ACTIVO (registered)
// ---------------------------------------------------------------------------
module diferencial_emisor_carriles #(
  parameter int CARRILES     = 4,
  parameter int ESTANCIA_MIN = 8,
  parameter int PREAMBULO    = 4,
  parameter int CIERRE       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enb,
  input  logic                TxElecIdle,
  input  logic [CARRILES-1:0] entrada,
`ifdef POLARIDAD_INVERTIBLE_EN
  input  logic [CARRILES-1:0] polaridad,
`endif
  output logic [CARRILES-1:0] salidaP,
  output logic [CARRILES-1:0] salidaN,
  output logic                enIdle,
  output logic                listo
);

  localparam int MAX_AB = (ESTANCIA_MIN > PREAMBULO) ? ESTANCIA_MIN : PREAMBULO;
  localparam int MAX_V  = (MAX_AB > CIERRE) ? MAX_AB : CIERRE;
  localparam int CW     = $clog2(MAX_V + 1);

  localparam logic [CW-1:0] C_EST     = CW'(ESTANCIA_MIN);
  localparam logic [CW-1:0] C_PRE_ULT = CW'(PREAMBULO - 1);
  localparam logic [CW-1:0] C_CIE_ULT = CW'(CIERRE - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SALIDA  = 2'd1,
    ACTIVO  = 2'd2,
    ENTRADA = 2'd3
  } estado_t;

  estado_t             r_est;
  estado_t             w_est_sig;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_sig;
  logic [CW-1:0]       w_idle_inc;
  logic [CARRILES-1:0] w_p;
  logic [CARRILES-1:0] w_n;
  logic [CARRILES-1:0] w_p_fin;
  logic [CARRILES-1:0] w_n_fin;
  logic [CARRILES-1:0] r_p;
  logic [CARRILES-1:0] r_n;
  logic                r_idle;
  logic                r_listo;

  // The IDLE dwell counter saturates so a long TxElecIdle request cannot wrap it.
  assign w_idle_inc = (r_cnt == C_EST) ? r_cnt : r_cnt + CW'(1);

  // Next-state and next-counter logic.
  always_comb begin
    w_est_sig = r_est;
    w_cnt_sig = r_cnt;
    case (r_est)
      IDLE: begin
        // Compare the incremented count so the dwell is exactly ESTANCIA_MIN cycles.
        if (!TxElecIdle && (w_idle_inc == C_EST)) begin
          w_est_sig = SALIDA;
          w_cnt_sig = {CW{1'b0}};
        end else begin
          w_cnt_sig = w_idle_inc;
        end
      end
      SALIDA: begin
        // The idle request is only looked at once the preamble is complete.
        if (r_cnt == C_PRE_ULT) begin
          w_est_sig = TxElecIdle ? ENTRADA : ACTIVO;
          w_cnt_sig = {CW{1'b0}};
        end else begin
          w_cnt_sig = r_cnt + CW'(1);
        end
      end
      ACTIVO: begin
        if (TxElecIdle) begin
          w_est_sig = ENTRADA;
          w_cnt_sig = {CW{1'b0}};
        end else begin
          w_cnt_sig = r_cnt;
        end
      end
      ENTRADA: begin
        if (r_cnt == C_CIE_ULT) begin
          w_est_sig = IDLE;
          w_cnt_sig = {CW{1'b0}};
        end else begin
          w_cnt_sig = r_cnt + CW'(1);
        end
      end
      default: begin
        w_est_sig = IDLE;
        w_cnt_sig = {CW{1'b0}};
      end
    endcase
  end

  // Lane pattern derived from the next state so the output register lines up with it.
  always_comb begin
    w_p = {CARRILES{1'b0}};
    w_n = {CARRILES{1'b0}};
    case (w_est_sig)
      IDLE: begin
        w_p = {CARRILES{1'b0}};
        w_n = {CARRILES{1'b0}};
      end
      SALIDA: begin
        // Even preamble cycles drive P high; the first preamble cycle has count 0.
        if (w_cnt_sig[0] == 1'b0) begin
          w_p = {CARRILES{1'b1}};
          w_n = {CARRILES{1'b0}};
        end else begin
          w_p = {CARRILES{1'b0}};
          w_n = {CARRILES{1'b1}};
        end
      end
      ACTIVO: begin
        w_p = entrada;
        w_n = ~entrada;
      end
      ENTRADA: begin
        w_p = {CARRILES{1'b0}};
        w_n = {CARRILES{1'b1}};
      end
      default: begin
        w_p = {CARRILES{1'b0}};
        w_n = {CARRILES{1'b0}};
      end
    endcase
  end

`ifdef POLARIDAD_INVERTIBLE_EN
  // Swapping the legs of a lane is a no-op in IDLE because both legs are 0 there.
  assign w_p_fin = (w_p & ~polaridad) | (w_n & polaridad);
  assign w_n_fin = (w_n & ~polaridad) | (w_p & polaridad);
`else
  assign w_p_fin = w_p;
  assign w_n_fin = w_n;
`endif

  // State, counter and registered outputs; enb low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_est   <= IDLE;
      r_cnt   <= {CW{1'b0}};
      r_p     <= {CARRILES{1'b0}};
      r_n     <= {CARRILES{1'b0}};
      r_idle  <= 1'b1;
      r_listo <= 1'b0;
    end else if (enb) begin
      r_est   <= w_est_sig;
      r_cnt   <= w_cnt_sig;
      r_p     <= w_p_fin;
      r_n     <= w_n_fin;
      r_idle  <= (w_est_sig == IDLE);
      r_listo <= (w_est_sig == ACTIVO);
    end
  end

  assign salidaP = r_p;
  assign salidaN = r_n;
  assign enIdle  = r_idle;
  assign listo   = r_listo;

endmodule

// File: tb/tb_diferencial_emisor_carriles.sv
// ---------------------------------------------------------------------------
// Testbench for diferencial_emisor_carriles (default parameters 4/8/4/2).
// A vector table scripts reset, the idle dwell, the exit preamble, data
// transfer, idle entry and reset from ACTIVO. Hand-written sequences cover
// an idle request during the preamble, enable freeze mid-preamble and, when
// POLARIDAD_INVERTIBLE_EN is defined, the per-lane polarity swap.
// ---------------------------------------------------------------------------
module tb_diferencial_emisor_carriles;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enb = 1'b1;
  logic       txi = 1'b0;
  logic [3:0] din = 4'h0;
`ifdef POLARIDAD_INVERTIBLE_EN
  logic [3:0] pol = 4'h0;
`endif
  logic [3:0] sp;
  logic [3:0] sn;
  logic       eidle;
  logic       lst;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst;
    logic       enb;
    logic       txi;
    logic [3:0] d;
    logic [3:0] ep;
    logic [3:0] en;
    logic       ei;
    logic       el;
  } vec_t;

  vec_t tabla[$];

  diferencial_emisor_carriles #(
    .CARRILES    (4),
    .ESTANCIA_MIN(8),
    .PREAMBULO   (4),
    .CIERRE      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .TxElecIdle(txi),
    .entrada   (din),
`ifdef POLARIDAD_INVERTIBLE_EN
    .polaridad (pol),
`endif
    .salidaP   (sp),
    .salidaN   (sn),
    .enIdle    (eidle),
    .listo     (lst)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic e, input logic t, input logic [3:0] d,
                     input logic [3:0] ep, input logic [3:0] en, input logic ei, input logic el);
    vec_t v;
    v.rst = r; v.enb = e; v.txi = t; v.d = d;
    v.ep = ep; v.en = en; v.ei = ei; v.el = el;
    tabla.push_back(v);
  endtask

  // Waits one rising edge, then compares all outputs 1 time unit later.
  task automatic step(input string nm, input logic [3:0] ep, input logic [3:0] en,
                      input logic ei, input logic el);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({sp, sn, eidle, lst} !== {ep, en, ei, el}) begin
      n_bad++;
      $display("FAIL %s: got P=%b N=%b enIdle=%b listo=%b, want P=%b N=%b enIdle=%b listo=%b",
               nm, sp, sn, eidle, lst, ep, en, ei, el);
    end
  endtask

  // Reset, then hold TxElecIdle low until the first preamble cycle is showing.
  task automatic to_preamble(input string nm);
    rst = 1'b1; enb = 1'b1; txi = 1'b0; din = 4'h0;
    step({nm, "_rst"}, 4'h0, 4'h0, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) step({nm, "_dwell"}, 4'h0, 4'h0, 1'b1, 1'b0);
    step({nm, "_pre0"}, 4'hF, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held for two cycles.
    add(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    // Dwell: 7 more idle cycles after the first one following reset.
    for (int i = 0; i < 7; i++) add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    // Preamble F,0,F,0.
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0);
    // ACTIVO: data with one-cycle latency.
    add(1'b0, 1'b1, 1'b0, 4'b1010, 4'b1010, 4'b0101, 1'b0, 1'b1);
    add(1'b0, 1'b1, 1'b0, 4'b0011, 4'b0011, 4'b1100, 1'b0, 1'b1);
    // Idle request for one cycle: closing pattern for 2 cycles, then IDLE.
    add(1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 4'hF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
    // Full dwell again before the next preamble; listo stays low throughout.
    for (int i = 0; i < 7; i++) add(1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 4'h0, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h5, 4'hF, 4'h0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 4'hF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h5, 4'hF, 4'h0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'h5, 4'h0, 4'hF, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 4'b0110, 4'b0110, 4'b1001, 1'b0, 1'b1);
    // Reset mid-ACTIVO.
    add(1'b1, 1'b1, 1'b0, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);

    for (int i = 0; i < tabla.size(); i++) begin
      rst = tabla[i].rst;
      enb = tabla[i].enb;
      txi = tabla[i].txi;
      din = tabla[i].d;
      step($sformatf("vec%0d", i), tabla[i].ep, tabla[i].en, tabla[i].ei, tabla[i].el);
    end

    // Idle request in the 2nd preamble cycle: preamble finishes, then closing, then IDLE.
    to_preamble("preidle");
    txi = 1'b1;
    step("preidle_p1", 4'h0, 4'hF, 1'b0, 1'b0);
    step("preidle_p2", 4'hF, 4'h0, 1'b0, 1'b0);
    step("preidle_p3", 4'h0, 4'hF, 1'b0, 1'b0);
    step("preidle_c0", 4'h0, 4'hF, 1'b0, 1'b0);
    step("preidle_c1", 4'h0, 4'hF, 1'b0, 1'b0);
    step("preidle_idle", 4'h0, 4'h0, 1'b1, 1'b0);
    txi = 1'b0;
    step("preidle_dwell", 4'h0, 4'h0, 1'b1, 1'b0);

    // Enable low for 3 cycles mid-preamble; inputs toggled meanwhile are ignored.
    to_preamble("freeze");
    step("freeze_p1", 4'h0, 4'hF, 1'b0, 1'b0);
    enb = 1'b0; txi = 1'b1; din = 4'hA;
    for (int i = 0; i < 3; i++) step("freeze_hold", 4'h0, 4'hF, 1'b0, 1'b0);
    enb = 1'b1; txi = 1'b0; din = 4'h9;
    step("freeze_p2", 4'hF, 4'h0, 1'b0, 1'b0);
    step("freeze_p3", 4'h0, 4'hF, 1'b0, 1'b0);
    step("freeze_act", 4'h9, 4'h6, 1'b0, 1'b1);

`ifdef POLARIDAD_INVERTIBLE_EN
    // Lane 0 swapped: P0 takes ~entrada[0], N0 takes entrada[0].
    to_preamble("pol");
    step("pol_p1", 4'h0, 4'hF, 1'b0, 1'b0);
    step("pol_p2", 4'hF, 4'h0, 1'b0, 1'b0);
    step("pol_p3", 4'h0, 4'hF, 1'b0, 1'b0);
    pol = 4'b0001; din = 4'b0001;
    step("pol_act", 4'b0000, 4'b1111, 1'b0, 1'b1);
    txi = 1'b1;
    step("pol_close", 4'b0001, 4'b1110, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
